// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - width/rdtype codes, FSM states and writeback bundle for the memory stage
package mem_access_unit_pkg;

  localparam logic [1:0] MW_NONE = 2'd0;
  localparam logic [1:0] MW_BYTE = 2'd1;
  localparam logic [1:0] MW_HALF = 2'd2;
  localparam logic [1:0] MW_WORD = 2'd3;

  localparam logic RD_SEXT = 1'b0;
  localparam logic RD_ZEXT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_REQ      = 2'd1,
    ST_WAIT_RSP = 2'd2,
    ST_DRAIN    = 2'd3
  } mau_state_t;

  typedef struct packed {
    logic [4:0]  rd;
    logic        reg_we;
    logic [31:0] wdata;
    logic        misalign;
    logic        buserr;
  } wb_t;

  function automatic logic is_misaligned(input logic [1:0] width, input logic [1:0] off);
    case (width)
      MW_HALF: return off[0];
      MW_WORD: return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_lane_align.sv
// rtl/mem_access_unit_lane_align.sv - combinational store lane steering and load extract/extend
module mem_lane_align
  import mem_access_unit_pkg::*;
(
  input  logic        i_st_load,
  input  logic [1:0]  i_st_width,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_data,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wdata,
  input  logic [1:0]  i_ld_width,
  input  logic [1:0]  i_ld_off,
  input  logic        i_ld_rdtype,
  input  logic [31:0] i_ld_rdata,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_shifted;
  logic        w_sext;

  always_comb begin
    o_st_be    = 4'h0;
    o_st_wdata = 32'h0;
    if (i_st_load) begin
      o_st_be = 4'hF;
    end else begin
      case (i_st_width)
        MW_BYTE: begin
          o_st_be    = 4'b0001 << i_st_off;
          o_st_wdata = {4{i_st_data[7:0]}};
        end
        MW_HALF: begin
          o_st_be    = 4'b0011 << i_st_off;
          o_st_wdata = {2{i_st_data[15:0]}};
        end
        MW_WORD: begin
          o_st_be    = 4'hF;
          o_st_wdata = i_st_data;
        end
        default: ;
      endcase
    end
  end

  assign w_shifted = i_ld_rdata >> {i_ld_off, 3'b000};
  assign w_sext    = (i_ld_rdtype == RD_SEXT);

  always_comb begin
    o_ld_data = i_ld_rdata;
    case (i_ld_width)
      MW_BYTE: o_ld_data = {{24{w_sext & w_shifted[7]}}, w_shifted[7:0]};
      MW_HALF: o_ld_data = {{16{w_sext & w_shifted[15]}}, w_shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - memory stage: single-outstanding bus FSM, timeout and registered writeback
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid_i,
  input  logic        ex_mtype_i,
  input  logic        ex_mem_rw_i,
  input  logic [1:0]  ex_mem_width_i,
  input  logic        ex_mem_rdtype_i,
  input  logic [31:0] ex_alu_res_i,
  input  logic [31:0] ex_rs2_data_i,
  input  logic [4:0]  ex_rd_i,
  input  logic        ex_reg_we_i,
  input  logic        flush_i,
  output logic        mem_stall_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  output logic [3:0]  bus_be_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_err_i,
  output logic        mem_valid_o,
  output logic [4:0]  mem_rd_o,
  output logic        mem_reg_we_o,
  output logic [31:0] mem_wdata_o,
  output logic        mem_misalign_o,
  output logic        mem_buserr_o
);

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYC - 1);

  mau_state_t  r_state, w_next_state;
  logic        r_req_we, r_req_load, r_req_rdtype, r_req_reg_we;
  logic [1:0]  r_req_width;
  logic [31:0] r_req_addr, r_req_wdata;
  logic [3:0]  r_req_be;
  logic [4:0]  r_req_rd;
  logic [15:0] r_cnt;
  logic        r_wb_valid;
  wb_t         r_wb;

  logic        w_accept, w_mem_op, w_misalign, w_start;
  logic        w_timeout, w_rsp_done, w_rsp_ok, w_rsp_err;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wdata, w_ld_data;

  assign w_accept   = (r_state == ST_IDLE) && ex_valid_i && !flush_i;
  assign w_mem_op   = ex_mtype_i && (ex_mem_width_i != MW_NONE);
  assign w_misalign = w_mem_op && is_misaligned(ex_mem_width_i, ex_alu_res_i[1:0]);
  assign w_start    = w_accept && w_mem_op && !w_misalign;
  assign w_timeout  = (r_cnt == TO_LAST);
  assign w_rsp_done = bus_rvalid_i || w_timeout;
  // A response that lands together with a timeout is still honoured.
  assign w_rsp_ok   = (r_state == ST_WAIT_RSP) && !flush_i && bus_rvalid_i && !bus_err_i;
  assign w_rsp_err  = (r_state == ST_WAIT_RSP) && !flush_i && (bus_rvalid_i ? bus_err_i : w_timeout);

  mem_lane_align u_lane_align (
    .i_st_load   (ex_mem_rw_i),
    .i_st_width  (ex_mem_width_i),
    .i_st_off    (ex_alu_res_i[1:0]),
    .i_st_data   (ex_rs2_data_i),
    .o_st_be     (w_st_be),
    .o_st_wdata  (w_st_wdata),
    .i_ld_width  (r_req_width),
    .i_ld_off    (r_req_addr[1:0]),
    .i_ld_rdtype (r_req_rdtype),
    .i_ld_rdata  (bus_rdata_i),
    .o_ld_data   (w_ld_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:     if (w_start) w_next_state = ST_REQ;
      ST_REQ: begin
        // Once granted the bus owes us a response, so a flush must drain it.
        if (bus_gnt_i)    w_next_state = flush_i ? ST_DRAIN : ST_WAIT_RSP;
        else if (flush_i) w_next_state = ST_IDLE;
      end
      ST_WAIT_RSP: begin
        if (w_rsp_done)   w_next_state = ST_IDLE;
        else if (flush_i) w_next_state = ST_DRAIN;
      end
      ST_DRAIN:    if (w_rsp_done) w_next_state = ST_IDLE;
      default:     w_next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    bus_req_o   = (r_state == ST_REQ);
    mem_stall_o = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= 16'd0;
    end else if (r_state == ST_REQ && bus_gnt_i) begin
      r_cnt <= 16'd0;
    end else if (r_state == ST_WAIT_RSP || r_state == ST_DRAIN) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_req_we     <= 1'b0;
      r_req_load   <= 1'b0;
      r_req_rdtype <= 1'b0;
      r_req_reg_we <= 1'b0;
      r_req_width  <= MW_NONE;
      r_req_addr   <= 32'h0;
      r_req_wdata  <= 32'h0;
      r_req_be     <= 4'h0;
      r_req_rd     <= 5'd0;
    end else if (w_start) begin
      r_req_we     <= !ex_mem_rw_i;
      r_req_load   <= ex_mem_rw_i;
      r_req_rdtype <= ex_mem_rdtype_i;
      r_req_reg_we <= ex_reg_we_i;
      r_req_width  <= ex_mem_width_i;
      r_req_addr   <= ex_alu_res_i;
      r_req_wdata  <= w_st_wdata;
      r_req_be     <= w_st_be;
      r_req_rd     <= ex_rd_i;
    end
  end

  assign bus_we_o    = r_req_we;
  assign bus_addr_o  = {r_req_addr[31:2], 2'b00};
  assign bus_wdata_o = r_req_wdata;
  assign bus_be_o    = r_req_be;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid <= 1'b0;
      r_wb       <= '0;
    end else begin
      r_wb_valid <= 1'b0;
      if (w_accept && !w_start) begin
        r_wb_valid     <= 1'b1;
        r_wb.rd        <= ex_rd_i;
        r_wb.reg_we    <= ex_reg_we_i && !ex_mtype_i;
        r_wb.wdata     <= ex_alu_res_i;
        r_wb.misalign  <= w_misalign;
        r_wb.buserr    <= 1'b0;
      end else if (w_rsp_ok) begin
        r_wb_valid     <= 1'b1;
        r_wb.rd        <= r_req_rd;
        r_wb.reg_we    <= r_req_load && r_req_reg_we;
        r_wb.wdata     <= r_req_load ? w_ld_data : r_req_addr;
        r_wb.misalign  <= 1'b0;
        r_wb.buserr    <= 1'b0;
      end else if (w_rsp_err) begin
        r_wb_valid     <= 1'b1;
        r_wb.rd        <= r_req_rd;
        r_wb.reg_we    <= 1'b0;
        r_wb.wdata     <= r_req_addr;
        r_wb.misalign  <= 1'b0;
        r_wb.buserr    <= 1'b1;
      end
    end
  end

  assign mem_valid_o    = r_wb_valid;
  assign mem_rd_o       = r_wb.rd;
  assign mem_reg_we_o   = r_wb.reg_we;
  assign mem_wdata_o    = r_wb.wdata;
  assign mem_misalign_o = r_wb.misalign;
  assign mem_buserr_o   = r_wb.buserr;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a byte-level reference model
module tb_mem_access_unit;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid_i = 0, ex_mtype_i = 0, ex_mem_rw_i = 0, ex_mem_rdtype_i = 0, ex_reg_we_i = 0;
  logic [1:0]  ex_mem_width_i = 0;
  logic [31:0] ex_alu_res_i = 0, ex_rs2_data_i = 0;
  logic [4:0]  ex_rd_i = 0;
  logic        flush_i = 0;
  logic        bus_gnt_i = 0, bus_rvalid_i = 0, bus_err_i = 0;
  logic [31:0] bus_rdata_i = 0;
  logic        mem_stall_o, bus_req_o, bus_we_o, mem_valid_o, mem_reg_we_o, mem_misalign_o, mem_buserr_o;
  logic [31:0] bus_addr_o, bus_wdata_o, mem_wdata_o;
  logic [3:0]  bus_be_o;
  logic [4:0]  mem_rd_o;

  always #5 clk = ~clk;

  mem_access_unit #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid_i(ex_valid_i), .ex_mtype_i(ex_mtype_i), .ex_mem_rw_i(ex_mem_rw_i),
    .ex_mem_width_i(ex_mem_width_i), .ex_mem_rdtype_i(ex_mem_rdtype_i),
    .ex_alu_res_i(ex_alu_res_i), .ex_rs2_data_i(ex_rs2_data_i), .ex_rd_i(ex_rd_i),
    .ex_reg_we_i(ex_reg_we_i), .flush_i(flush_i), .mem_stall_o(mem_stall_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_gnt_i(bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i), .bus_err_i(bus_err_i),
    .mem_valid_o(mem_valid_o), .mem_rd_o(mem_rd_o), .mem_reg_we_o(mem_reg_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_misalign_o(mem_misalign_o), .mem_buserr_o(mem_buserr_o)
  );

  typedef struct {
    int          gnt_delay;
    int          rsp_delay;
    bit          no_rsp;
    bit          err;
    logic [31:0] rdata;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_plan_t;

  typedef struct {
    logic [4:0]  rd;
    logic        reg_we;
    logic [31:0] wdata;
    bit          chk_wdata;
    logic        misalign;
    logic        buserr;
  } exp_t;

  bus_plan_t plan_q[$];
  exp_t      exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  function automatic int size_of(input logic [1:0] width);
    return (width == 2'd3) ? 4 : int'(width);
  endfunction

  // Byte-addressed view: lane i of the word carries byte (i mod size) of rs2.
  function automatic void ref_store(input logic [1:0] width, input logic [31:0] addr,
                                    input logic [31:0] rs2, output logic [3:0] be,
                                    output logic [31:0] wd);
    int size = size_of(width);
    int off  = int'(addr[1:0]);
    be = 4'h0;
    wd = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + size) be[i] = 1'b1;
      wd[8*i +: 8] = rs2[8*(i % size) +: 8];
    end
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] width, input logic [31:0] addr,
                                           input logic rdtype, input logic [31:0] rdata);
    int size = size_of(width);
    int off  = int'(addr[1:0]);
    longint v = 0;
    for (int k = 0; k < size; k++) v += longint'(rdata[8*(off+k) +: 8]) << (8*k);
    if (size < 4 && rdtype == 1'b0 && v >= (longint'(1) << (8*size-1)))
      v -= (longint'(1) << (8*size));
    return 32'(v);
  endfunction

  task automatic issue(input logic mtype, input logic rw, input logic [1:0] width,
                       input logic rdtype, input logic [31:0] alu, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic we, input int gnt_delay,
                       input int rsp_delay, input bit no_rsp, input bit err,
                       input logic [31:0] rdata, input int flush_at);
    bit mem_op, misal, req_flush;
    int exp_stall, stall_cnt, guard;
    bus_plan_t p;
    exp_t e;
    mem_op    = mtype && width != 2'd0;
    misal     = mem_op && ((width == 2'd2 && alu[0]) || (width == 2'd3 && alu[1:0] != 2'b00));
    req_flush = flush_at >= 0 && flush_at < gnt_delay;
    exp_stall = 0;
    e = '{rd: rd, reg_we: 1'b0, wdata: alu, chk_wdata: 1'b0, misalign: 1'b0, buserr: 1'b0};
    if (!mem_op) begin
      e.reg_we = we && !mtype;
      e.chk_wdata = 1'b1;
      exp_q.push_back(e);
    end else if (misal) begin
      e.misalign = 1'b1;
      exp_q.push_back(e);
    end else begin
      p.gnt_delay = gnt_delay; p.rsp_delay = rsp_delay; p.no_rsp = no_rsp; p.err = err;
      p.rdata = rdata; p.addr = {alu[31:2], 2'b00}; p.we = !rw;
      if (rw) begin p.be = 4'hF; p.wdata = 32'h0; end
      else ref_store(width, alu, rs2, p.be, p.wdata);
      plan_q.push_back(p);
      exp_stall = req_flush ? flush_at + 1 : gnt_delay + 1 + (no_rsp ? TO : rsp_delay);
      if (flush_at < 0) begin
        if (no_rsp || err) e.buserr = 1'b1;
        else if (rw) begin
          e.reg_we = we;
          e.wdata = ref_load(width, alu, rdtype, rdata);
          e.chk_wdata = 1'b1;
        end
        exp_q.push_back(e);
      end
    end
    guard = 0;
    @(negedge clk);
    while (mem_stall_o && guard < 200) begin @(negedge clk); guard++; end
    ex_mtype_i = mtype; ex_mem_rw_i = rw; ex_mem_width_i = width; ex_mem_rdtype_i = rdtype;
    ex_alu_res_i = alu; ex_rs2_data_i = rs2; ex_rd_i = rd; ex_reg_we_i = we; ex_valid_i = 1'b1;
    @(negedge clk);
    ex_valid_i = 1'b0;
    ex_alu_res_i = $urandom; ex_rs2_data_i = $urandom; ex_rd_i = 5'($urandom);
    stall_cnt = 0;
    while (mem_stall_o && stall_cnt < 300) begin
      flush_i = (stall_cnt == flush_at);
      stall_cnt++;
      @(negedge clk);
    end
    flush_i = 1'b0;
    check("stall_cycles", stall_cnt, exp_stall);
    if (mem_op && !misal && req_flush) check("req_drop_after_flush", {31'd0, bus_req_o}, 32'd0);
  endtask

  // Bus slave: follows the plan queued by the stimulus side.
  bus_plan_t bp;
  initial begin
    bit aborted;
    forever begin
      @(negedge clk);
      if (rst_n && bus_req_o) begin
        if (plan_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_bus_req actual=1 required=0 addr=0x%08h", bus_addr_o);
          @(negedge clk);
        end else begin
          bp = plan_q.pop_front();
          check("bus_addr", bus_addr_o, bp.addr);
          check("bus_we", {31'd0, bus_we_o}, {31'd0, bp.we});
          check("bus_be", {28'd0, bus_be_o}, {28'd0, bp.be});
          check("bus_wdata", bus_wdata_o, bp.wdata);
          aborted = 1'b0;
          for (int d = 0; d < bp.gnt_delay; d++) begin
            @(negedge clk);
            if (!bus_req_o) begin aborted = 1'b1; break; end
          end
          if (!aborted) begin
            check("bus_addr_at_gnt", bus_addr_o, bp.addr);
            bus_gnt_i = 1'b1;
            @(negedge clk);
            bus_gnt_i = 1'b0;
            if (!bp.no_rsp) begin
              for (int d = 1; d < bp.rsp_delay; d++) @(negedge clk);
              bus_rvalid_i = 1'b1; bus_rdata_i = bp.rdata; bus_err_i = bp.err;
              @(negedge clk);
              bus_rvalid_i = 1'b0; bus_err_i = 1'b0; bus_rdata_i = $urandom;
            end
          end
        end
      end
    end
  end

  exp_t me;
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && mem_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_mem_valid actual=1 required=0 rd=%0d", mem_rd_o);
        end else begin
          me = exp_q.pop_front();
          check("wb_rd", {27'd0, mem_rd_o}, {27'd0, me.rd});
          check("wb_reg_we", {31'd0, mem_reg_we_o}, {31'd0, me.reg_we});
          check("wb_misalign", {31'd0, mem_misalign_o}, {31'd0, me.misalign});
          check("wb_buserr", {31'd0, mem_buserr_o}, {31'd0, me.buserr});
          if (me.chk_wdata) check("wb_wdata", mem_wdata_o, me.wdata);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_stall"}, {31'd0, mem_stall_o}, 32'd0);
    check({tag, "_bus_req"}, {31'd0, bus_req_o}, 32'd0);
    check({tag, "_bus_sigs"}, bus_addr_o | bus_wdata_o | {27'd0, bus_be_o, bus_we_o}, 32'd0);
    check({tag, "_mem_valid"}, {31'd0, mem_valid_o}, 32'd0);
    check({tag, "_mem_sigs"}, mem_wdata_o | {25'd0, mem_rd_o, mem_reg_we_o, mem_misalign_o} | {31'd0, mem_buserr_o}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  w;
    logic [31:0] a;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // SB, LB, LBU, LH with fixed bus timing
    issue(1, 0, 2'd1, 0, 32'h0000_1003, 32'h0000_00A5, 5'd3, 1, 0, 2, 0, 0, 32'h0, -1);
    issue(1, 1, 2'd1, 0, 32'h0000_2001, 32'h0, 5'd7, 1, 0, 2, 0, 0, 32'h1234_80FF, -1);
    issue(1, 1, 2'd1, 1, 32'h0000_2001, 32'h0, 5'd8, 1, 1, 1, 0, 0, 32'h1234_80FF, -1);
    issue(1, 1, 2'd2, 0, 32'h0000_2002, 32'h0, 5'd9, 1, 0, 3, 0, 0, 32'h8001_0000, -1);
    // misaligned LW and SH, ADD passthrough, mtype with width none
    issue(1, 1, 2'd3, 0, 32'h0000_3002, 32'h0, 5'd10, 1, 0, 1, 0, 0, 32'h0, -1);
    issue(1, 0, 2'd2, 0, 32'h0000_3001, 32'h1234, 5'd11, 1, 0, 1, 0, 0, 32'h0, -1);
    issue(0, 0, 2'd0, 0, 32'hDEAD_BEEF, 32'h0, 5'd5, 1, 0, 1, 0, 0, 32'h0, -1);
    issue(1, 1, 2'd0, 0, 32'h0BAD_F00D, 32'h0, 5'd6, 1, 0, 1, 0, 0, 32'h0, -1);
    // timeout, error response, flush in REQ, flush in WAIT_RSP
    issue(1, 1, 2'd3, 0, 32'h0000_4000, 32'h0, 5'd12, 1, 0, 1, 1, 0, 32'h0, -1);
    issue(1, 1, 2'd3, 0, 32'h0000_4004, 32'h0, 5'd13, 1, 1, 1, 0, 1, 32'h5555_AAAA, -1);
    issue(1, 0, 2'd3, 0, 32'h0000_5000, 32'h1111_2222, 5'd14, 0, 100, 1, 0, 0, 32'h0, 2);
    issue(1, 1, 2'd3, 0, 32'h0000_5004, 32'h0, 5'd15, 1, 0, 6, 0, 0, 32'hCAFE_0001, 2);
    repeat (4) @(negedge clk);

    // asynchronous reset in the middle of a request
    begin
      bus_plan_t rp;
      rp = '{gnt_delay: 100, rsp_delay: 1, no_rsp: 0, err: 0, rdata: 32'h0,
             addr: 32'h0000_6000, we: 1'b0, be: 4'hF, wdata: 32'h0};
      plan_q.push_back(rp);
      ex_mtype_i = 1; ex_mem_rw_i = 1; ex_mem_width_i = 2'd3; ex_alu_res_i = 32'h0000_6000;
      ex_rd_i = 5'd16; ex_reg_we_i = 1; ex_valid_i = 1;
      @(negedge clk);
      ex_valid_i = 0;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_all_zero("midreq_reset");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
    end

    for (int n = 0; n < 60; n++) begin
      w = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (w == 2'd2) a[0] = 1'b0;
        if (w == 2'd3) a[1:0] = 2'b00;
      end
      if ($urandom_range(0, 3) == 0)
        issue(0, 1'($urandom), w, 1'($urandom), a, $urandom, 5'($urandom), 1'($urandom),
              0, 1, 0, 0, 32'h0, -1);
      else
        issue(1, 1'($urandom), w, 1'($urandom), a, $urandom, 5'($urandom), 1'($urandom),
              $urandom_range(0, 3), $urandom_range(1, 4), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 7) == 0), $urandom, -1);
    end

    repeat (20) @(negedge clk);
    check("exp_queue_empty", exp_q.size(), 32'd0);
    check("plan_queue_empty", plan_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
